adt7420_i2c_target: RTL

ADT7420_I2C_TARGET -- requirements
Module: adt7420_i2c_target

---
 rtl/adt7420_i2c_target.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/adt7420_i2c_target.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adt7420_i2c_target
//   I2C target that mimics the register map of an ADT7420 temperature sensor.
//   SCL and SDA are oversampled by the system clock; no clock stretching.
//
//   Register map (8-bit auto-incrementing pointer, wraps 0xFF -> 0x00):
//     0x00 temperature MSB (shadow[15:8])   0x01 temperature LSB (shadow[7:0])
//     0x02 status (always 0x00)             0x03 config (read/write)
//     0x0B device ID (DEV_ID, only with ADT7420_ID_REG_EN defined)
//     all other addresses read 0x00, writes are discarded
//
//   Build option: define ADT7420_ID_REG_EN to make register 0x0B return DEV_ID.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     scl_i      raw SCL pin level
//     sda_i      raw SDA pin level
//     sda_oe     1 = pull SDA low, 0 = release (open drain)
//     temp_in    temperature word, captured at the start of each read
//     config_out config register contents
//     busy       high from an address match until the next START or STOP
//     rd_strobe  one-clk pulse per read byte the controller ACKs
// -----------------------------------------------------------------------------
module adt7420_i2c_target #(
    parameter logic [6:0] I2C_ADDR = 7'h4B,
    parameter logic [7:0] DEV_ID   = 8'hCB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_out,
    output logic        busy,
    output logic        rd_strobe
);

`ifdef ADT7420_ID_REG_EN
    localparam logic [7:0] ID_RD = DEV_ID;
`else
    // ID register disabled: 0x0B reads like unmapped space.
    localparam logic [7:0] ID_RD = DEV_ID & 8'h00;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // ---------------------------------------------------------------- sync
    // Two synchronizer flops plus one history flop per line; preset high so
    // an idle bus produces no events coming out of reset.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_d_q, sda_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_d_q    <= scl_sync_q[1];
            sda_d_q    <= sda_sync_q[1];
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = scl_sync_q[1];
    assign sda_f     = sda_sync_q[1];
    assign scl_rise  =  scl_f & ~scl_d_q;
    assign scl_fall  = ~scl_f &  scl_d_q;
    // SDA may only move with SCL high to signal START/STOP; require SCL high
    // on both samples so an SCL edge coinciding with SDA is not misread.
    assign start_det = scl_f & scl_d_q &  sda_d_q & ~sda_f;
    assign stop_det  = scl_f & scl_d_q & ~sda_d_q &  sda_f;

    // ---------------------------------------------------------------- state
    state_t      state_q;
    logic [3:0]  cnt_q;      // SCL rises seen in the current byte
    logic [7:0]  sr_q;       // receive shift register
    logic [7:0]  tx_q;       // remaining transmit bits, MSB next
    logic [7:0]  ptr_q;
    logic [7:0]  cfg_q;
    logic [15:0] shadow_q;
    logic        rw_q;
    logic        ack_q;      // controller ACKed the last read byte
    logic        sda_oe_q;
    logic        busy_q;
    logic        rd_strobe_q;

    function automatic logic [7:0] rd_byte(input logic [7:0]  p,
                                           input logic [15:0] shd,
                                           input logic [7:0]  cfg);
        case (p)
            8'h00:   rd_byte = shd[15:8];
            8'h01:   rd_byte = shd[7:0];
            8'h03:   rd_byte = cfg;
            8'h0B:   rd_byte = ID_RD;
            default: rd_byte = 8'h00;
        endcase
    endfunction

    // First byte of a read is taken from temp_in directly because the shadow
    // is being loaded on the same edge; later bytes come from the shadow.
    logic [7:0] first_byte, next_byte;
    logic       byte_done;
    assign first_byte = rd_byte(ptr_q, temp_in,  cfg_q);
    assign next_byte  = rd_byte(ptr_q, shadow_q, cfg_q);
    assign byte_done  = scl_fall && (cnt_q == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sr_q        <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            cfg_q       <= 8'h00;
            shadow_q    <= 16'h0000;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            rd_strobe_q <= 1'b0;
            if (start_det) begin
                state_q  <= ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                // Bit sampling is common to all byte states; counter stops at 8
                // so the ACK clock never disturbs a finished byte.
                if (scl_rise && cnt_q != 4'd8) begin
                    sr_q  <= {sr_q[6:0], sda_f};
                    cnt_q <= cnt_q + 4'd1;
                end
                case (state_q)
                    ADDR: if (byte_done) begin
                        if (sr_q[7:1] == I2C_ADDR) begin
                            state_q  <= ADDR_ACK;
                            rw_q     <= sr_q[0];
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= WAIT_STOP;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        cnt_q <= 4'd0;
                        if (rw_q) begin
                            state_q  <= RD_DATA;
                            shadow_q <= temp_in;
                            sda_oe_q <= ~first_byte[7];
                            tx_q     <= {first_byte[6:0], 1'b0};
                        end else begin
                            state_q  <= PTR;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    PTR: if (byte_done) begin
                        state_q  <= PTR_ACK;
                        ptr_q    <= sr_q;
                        sda_oe_q <= 1'b1;
                    end
                    WR_DATA: if (byte_done) begin
                        state_q  <= WR_ACK;
                        if (ptr_q == 8'h03) cfg_q <= sr_q;
                        ptr_q    <= ptr_q + 8'd1;
                        sda_oe_q <= 1'b1;
                    end
                    PTR_ACK, WR_ACK: if (scl_fall) begin
                        state_q  <= WR_DATA;
                        cnt_q    <= 4'd0;
                        sda_oe_q <= 1'b0;
                    end
                    RD_DATA: if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_q  <= RD_ACK;
                            sda_oe_q <= 1'b0;
                        end else begin
                            sda_oe_q <= ~tx_q[7];
                            tx_q     <= {tx_q[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_q <= ~sda_f;
                            if (!sda_f) begin
                                rd_strobe_q <= 1'b1;
                                ptr_q       <= ptr_q + 8'd1;
                            end
                        end else if (scl_fall) begin
                            if (ack_q) begin
                                // ptr_q already advanced on the ACK rise
                                state_q  <= RD_DATA;
                                cnt_q    <= 4'd0;
                                sda_oe_q <= ~next_byte[7];
                                tx_q     <= {next_byte[6:0], 1'b0};
                            end else begin
                                state_q  <= WAIT_STOP;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign config_out = cfg_q;
    assign busy       = busy_q;
    assign rd_strobe  = rd_strobe_q;

endmodule
